// File: rtl/div_pkg.sv
// Shared types and constants for the divider host sequencer.
package div_pkg;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned START_CNT_W   = 3;
  localparam int unsigned TIMEOUT_CNT_W = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_DZ = 2'b01;
  localparam logic [1:0] ERR_TO = 2'b10;

endpackage

// File: rtl/div_host_seq_if.sv
// Operand stream, divider handshake and result stream of the divider host sequencer.
interface div_host_seq_if #(parameter int unsigned W = div_pkg::DEF_W);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         div_start;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_busy;
  logic         div_ready;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;
  logic [1:0]   out_err;
  logic         active;

  modport master (
    input  in_valid, in_dividend, in_divisor, div_busy, div_ready, div_quot, div_rem, out_ready,
    output in_ready, div_start, div_dividend, div_divisor, out_valid, out_quot, out_rem,
           out_err, active
  );

  modport slave (
    output in_valid, in_dividend, in_divisor, div_busy, div_ready, div_quot, div_rem, out_ready,
    input  in_ready, div_start, div_dividend, div_divisor, out_valid, out_quot, out_rem,
           out_err, active
  );

endinterface

// File: rtl/div_host_timer.sv
// Loadable saturating up-counter; atLimit_c flags count >= limit.
module div_host_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             atLimit_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign atLimit_c = (count >= limit);

endmodule

// File: rtl/div_host_seq.sv
// Initiator side of the divider start/busy/ready handshake with zero-divisor and timeout detection.
module div_host_seq
  import div_pkg::*;
#(
  parameter int unsigned W         = DEF_W,
  parameter int unsigned START_LEN = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic            clk,
  input logic            reset,
  div_host_seq_if.master bus
);

  state_t       state, nextState;
  logic         inReady, nInReady;
  logic         divStart, nDivStart;
  logic [W-1:0] divDividend, nDivDividend;
  logic [W-1:0] divDivisor, nDivDivisor;
  logic         outValid, nOutValid;
  logic [W-1:0] outQuot, nOutQuot;
  logic [W-1:0] outRem, nOutRem;
  logic [1:0]   outErr, nOutErr;
  logic         activeReg;

  logic accept;
  logic inFlight;
  logic startDone;
  logic timeoutHit;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign inFlight = (state == START) || (state == WAIT_BUSY) || (state == WAIT_DONE);

  div_host_timer #(.WIDTH(START_CNT_W)) startTimer (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .en        (state == START),
    .limit     (START_CNT_W'(START_LEN - 1)),
    .atLimit_c (startDone)
  );

  // Terminal on the TIMEOUT-th in-flight cycle, so the abort lands TIMEOUT cycles after start rises.
  div_host_timer #(.WIDTH(TIMEOUT_CNT_W)) timeoutTimer (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .en        (inFlight),
    .limit     (TIMEOUT_CNT_W'(TIMEOUT - 1)),
    .atLimit_c (timeoutHit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      inReady     <= 1'b1;
      divStart    <= 1'b0;
      divDividend <= '0;
      divDivisor  <= '0;
      outValid    <= 1'b0;
      outQuot     <= '0;
      outRem      <= '0;
      outErr      <= ERR_OK;
      activeReg   <= 1'b0;
    end else begin
      state       <= nextState;
      inReady     <= nInReady;
      divStart    <= nDivStart;
      divDividend <= nDivDividend;
      divDivisor  <= nDivDivisor;
      outValid    <= nOutValid;
      outQuot     <= nOutQuot;
      outRem      <= nOutRem;
      outErr      <= nOutErr;
      activeReg   <= (nextState != IDLE);
    end
  end

  always_comb begin
    nextState    = state;
    nInReady     = inReady;
    nDivStart    = divStart;
    nDivDividend = divDividend;
    nDivDivisor  = divDivisor;
    nOutValid    = outValid;
    nOutQuot     = outQuot;
    nOutRem      = outRem;
    nOutErr      = outErr;

    case (state)
      IDLE: begin
        nInReady = 1'b1;
        if (bus.in_valid) begin
          nInReady     = 1'b0;
          nDivDividend = bus.in_dividend;
          nDivDivisor  = bus.in_divisor;
          if (bus.in_divisor == '0) begin
            nextState = RESP;
            nOutValid = 1'b1;
            nOutQuot  = '1;
            nOutRem   = bus.in_dividend;
            nOutErr   = ERR_DZ;
          end else begin
            nextState = START;
            nDivStart = 1'b1;
          end
        end
      end
      START: begin
        if (timeoutHit) begin
          nextState = RESP;
          nDivStart = 1'b0;
          nOutValid = 1'b1;
          nOutQuot  = '0;
          nOutRem   = '0;
          nOutErr   = ERR_TO;
        end else if (startDone) begin
          nextState = WAIT_BUSY;
          nDivStart = 1'b0;
        end
      end
      WAIT_BUSY, WAIT_DONE: begin
        // A ready pulse beats a coinciding timeout; a short op may skip busy entirely.
        if (bus.div_ready) begin
          nextState = RESP;
          nOutValid = 1'b1;
          nOutQuot  = bus.div_quot;
          nOutRem   = bus.div_rem;
          nOutErr   = ERR_OK;
        end else if (timeoutHit) begin
          nextState = RESP;
          nOutValid = 1'b1;
          nOutQuot  = '0;
          nOutRem   = '0;
          nOutErr   = ERR_TO;
        end else if ((state == WAIT_BUSY) && bus.div_busy) begin
          nextState = WAIT_DONE;
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          nextState = IDLE;
          nOutValid = 1'b0;
          nInReady  = 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
        nInReady  = 1'b1;
        nDivStart = 1'b0;
        nOutValid = 1'b0;
      end
    endcase
  end

  assign bus.in_ready     = inReady;
  assign bus.div_start    = divStart;
  assign bus.div_dividend = divDividend;
  assign bus.div_divisor  = divDivisor;
  assign bus.out_valid    = outValid;
  assign bus.out_quot     = outQuot;
  assign bus.out_rem      = outRem;
  assign bus.out_err      = outErr;
  assign bus.active       = activeReg;

endmodule
